awg_seq_ctrl: RTL
=================

Name: awg_seq_ctrl

Overview:
Step sequencer that drives the waveform-select and shaping inputs of sig_gen: state, state_freq, state_amp and state_phase.
A host loads a small program table. Each entry holds a waveform code, frequency, amplitude, phase and dwell time.
The block plays the entries in order, optionally looping. Between steps it inserts a muted gap (state code 5'd10) so waveform generators switch cleanly.

Parameters:
DEPTH, 8, number of program-table entries
AW, 3, table address width (log2 DEPTH)
DWELL_W, 24, width of per-step dwell count in clk cycles
GAP_CYC, 4, muted cycles inserted before each step (range 1..15)

Ports:
clk  in  1  system clock, same as the sig_gen/DAC clock
rst_n  in  1  synchronous, active-low reset
cfg_we  in  1  table write strobe
cfg_addr  in  AW  table write address
cfg_wave  in  5  waveform code (0 saw, 1 tri, 2 sqr, 3 sin, 4 noise)
cfg_freq  in  12  frequency word
cfg_amp  in  3  amplitude code
cfg_phase  in  8  phase word
cfg_dwell  in  DWELL_W  step duration in cycles
last_idx  in  AW  index of the final step of the program
loop_en  in  1  restart at index 0 after last_idx
start  in  1  begin playback (level-sampled)
stop  in  1  abort playback
state  out  5  to sig_gen state
state_freq  out  12  to sig_gen state_freq
state_amp  out  3  to sig_gen state_amp
state_phase  out  8  to sig_gen state_phase
busy  out  1  high in LOAD/GAP/RUN
step_idx  out  AW  index of the current entry
step_strobe  out  1  one-cycle pulse on the first RUN cycle of each step
done  out  1  one-cycle pulse when a non-looping program ends
cfg_err  out  1  one-cycle pulse when a write is rejected

Behaviour:
- Reset (rst_n=0 at posedge): FSM goes to IDLE.
  - state=5'd10; state_freq, state_amp, state_phase = 0.
  - busy, step_strobe, done, cfg_err = 0; step_idx=0.
  - Table contents are NOT reset.
- Table writes:
  - Accepted only in IDLE; the entry is updated at the posedge where cfg_we=1.
  - cfg_we while busy: table unchanged; cfg_err=1 on the next cycle.
- FSM states: IDLE, LOAD, GAP, RUN, DONE.
- IDLE:
  - Outputs muted (state=5'd10).
  - start=1 and stop=0 -> LOAD, step_idx=0.
- LOAD (1 cycle):
  - Registers entry[step_idx] into the working registers.
  - -> GAP with gap counter = GAP_CYC-1.
- GAP (GAP_CYC cycles):
  - state=5'd10.
  - state_freq, state_amp, state_phase already show the new entry.
  - When the counter reaches 0 -> RUN, with dwell counter = max(dwell,1)-1.
- RUN (max(dwell,1) cycles):
  - state=entry wave.
  - step_strobe=1 on the first RUN cycle only.
  - When the counter reaches 0:
    - step_idx != last_idx -> step_idx+1, LOAD.
    - step_idx == last_idx and loop_en=1 -> step_idx=0, LOAD.
    - step_idx == last_idx and loop_en=0 -> DONE.
- DONE (1 cycle):
  - done=1, outputs muted.
  - -> IDLE. start is ignored in this cycle.
- Step timing: period = 1 + GAP_CYC + max(dwell,1) cycles.
  - start sampled at edge k -> first RUN cycle after edge k+1+GAP_CYC.
- stop=1 in any busy state:
  - -> IDLE at the next edge; outputs muted in the same update.
  - No done pulse is produced.
  - stop has priority over start and over counter expiry in the same cycle.
- start while busy is ignored.
- loop_en and last_idx are sampled at each step-end decision; changes mid-program take effect at the next boundary.
- last_idx >= DEPTH cannot occur, since AW is exactly log2 DEPTH.
- dwell=0 behaves as dwell=1.
- All outputs are registered; there is no combinational path from any input to any output.
- Reset mid-playback overrides everything and returns the block to IDLE at the same edge.

Test Plan:
1. Write entries 0 and 1 in IDLE:
   - entry0 {wave=0, freq=12'h100, amp=3, phase=0, dwell=10}; entry1 {wave=3, freq=12'h200, amp=7, phase=8'h40, dwell=5}.
   - Set last_idx=1, loop_en=0, pulse start.
   - Expect: LOAD 1 cycle; state=10 for 4 cycles; state=0 for 10 cycles; LOAD; 4 muted cycles; state=3 for 5 cycles; done pulse; IDLE.
   - step_strobe exactly twice.
2. Same program with loop_en=1, run for 3 periods:
   - Period = (1+4+10)+(1+4+5) = 25 cycles.
   - step_idx sequence 0,1,0,1,0,1; done is never asserted.
3. Assert stop during the 3rd RUN cycle of entry0:
   - Next cycle: state=10, busy=0, no done.
   - Start again: playback restarts at step_idx=0.
4. cfg_we to address 0 while busy:
   - cfg_err pulses; the table is unchanged, checked by replaying entry0 values.
5. Entry with dwell=0 -> exactly 1 RUN cycle.
   - start and stop asserted together in IDLE -> FSM stays IDLE.
6. Assert rst_n=0 for 1 cycle mid-GAP:
   - All outputs reach their reset values at that edge.
   - Table contents are retained: a subsequent start replays the previously written values.

Source files
------------

// File: rtl/awg_seq_ctrl.sv
// Step sequencer feeding sig_gen: plays a host-loaded table of waveform steps,
// with a muted gap before each step so the generator switches cleanly.
module awg_seq_ctrl #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned AW      = 3,
    parameter int unsigned DWELL_W = 24,
    parameter int unsigned GAP_CYC = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [4:0]         cfg_wave,
    input  logic [11:0]        cfg_freq,
    input  logic [2:0]         cfg_amp,
    input  logic [7:0]         cfg_phase,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [AW-1:0]      last_idx,
    input  logic               loop_en,
    input  logic               start,
    input  logic               stop,
    output logic [4:0]         state,
    output logic [11:0]        state_freq,
    output logic [2:0]         state_amp,
    output logic [7:0]         state_phase,
    output logic               busy,
    output logic [AW-1:0]      step_idx,
    output logic               step_strobe,
    output logic               done,
    output logic               cfg_err
);

    localparam int unsigned GAP_W = 4;
    localparam logic [4:0]  MUTE  = 5'd10;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GAP, S_RUN, S_DONE} fsm_t;

    fsm_t               fsm;
    logic [GAP_W-1:0]   gap_cnt;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] w_dwell;
    logic [4:0]         w_wave;
    logic               fsm_busy;

    logic [4:0]         tbl_wave  [DEPTH];
    logic [11:0]        tbl_freq  [DEPTH];
    logic [2:0]         tbl_amp   [DEPTH];
    logic [7:0]         tbl_phase [DEPTH];
    logic [DWELL_W-1:0] tbl_dwell [DEPTH];

    assign fsm_busy = (fsm == S_LOAD) || (fsm == S_GAP) || (fsm == S_RUN);

    // Program table: no reset so contents survive a mid-playback reset.
    always_ff @(posedge clk) begin
        if (cfg_we && (fsm == S_IDLE)) begin
            tbl_wave[cfg_addr]  <= cfg_wave;
            tbl_freq[cfg_addr]  <= cfg_freq;
            tbl_amp[cfg_addr]   <= cfg_amp;
            tbl_phase[cfg_addr] <= cfg_phase;
            tbl_dwell[cfg_addr] <= cfg_dwell;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm         <= S_IDLE;
            state       <= MUTE;
            state_freq  <= '0;
            state_amp   <= '0;
            state_phase <= '0;
            busy        <= 1'b0;
            step_idx    <= '0;
            step_strobe <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
            gap_cnt     <= '0;
            dwell_cnt   <= '0;
            w_dwell     <= '0;
            w_wave      <= '0;
        end else begin
            step_strobe <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= cfg_we && (fsm != S_IDLE);

            // stop wins over start and over step-end decisions
            if (stop && fsm_busy) begin
                fsm         <= S_IDLE;
                busy        <= 1'b0;
                state       <= MUTE;
                state_freq  <= '0;
                state_amp   <= '0;
                state_phase <= '0;
            end else begin
                case (fsm)
                    S_IDLE: begin
                        if (start && !stop) begin
                            fsm      <= S_LOAD;
                            busy     <= 1'b1;
                            step_idx <= '0;
                        end
                    end
                    S_LOAD: begin
                        state       <= MUTE;
                        state_freq  <= tbl_freq[step_idx];
                        state_amp   <= tbl_amp[step_idx];
                        state_phase <= tbl_phase[step_idx];
                        w_wave      <= tbl_wave[step_idx];
                        w_dwell     <= (tbl_dwell[step_idx] == '0) ? '0
                                     : tbl_dwell[step_idx] - DWELL_W'(1);
                        gap_cnt     <= GAP_W'(GAP_CYC - 1);
                        fsm         <= S_GAP;
                    end
                    S_GAP: begin
                        if (gap_cnt == '0) begin
                            fsm         <= S_RUN;
                            state       <= w_wave;
                            step_strobe <= 1'b1;
                            dwell_cnt   <= w_dwell;
                        end else begin
                            gap_cnt <= gap_cnt - GAP_W'(1);
                        end
                    end
                    S_RUN: begin
                        if (dwell_cnt == '0) begin
                            state <= MUTE;
                            if (step_idx != last_idx) begin
                                step_idx <= step_idx + AW'(1);
                                fsm      <= S_LOAD;
                            end else if (loop_en) begin
                                step_idx <= '0;
                                fsm      <= S_LOAD;
                            end else begin
                                fsm         <= S_DONE;
                                busy        <= 1'b0;
                                done        <= 1'b1;
                                state_freq  <= '0;
                                state_amp   <= '0;
                                state_phase <= '0;
                            end
                        end else begin
                            dwell_cnt <= dwell_cnt - DWELL_W'(1);
                        end
                    end
                    S_DONE: begin
                        fsm <= S_IDLE;
                    end
                    default: begin
                        fsm  <= S_IDLE;
                        busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
